// File: rtl/reu_pkg.sv
// REU shared definitions: transfer types and the DMA sequencer state encoding.
// Also imported by the REU register file.
package reu_pkg;

  localparam logic [1:0] STASH  = 2'b00;
  localparam logic [1:0] FETCH  = 2'b01;
  localparam logic [1:0] SWAP   = 2'b10;
  localparam logic [1:0] VERIFY = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    START = 3'd2,
    XFER  = 3'd3,
    SWAPW = 3'd4,
    DONE  = 3'd5
  } seqState_t;

endpackage

// File: rtl/reu_dma_seq_if.sv
// Expansion-port and REU RAM data path seen by the DMA sequencer.
// master = sequencer, slave = bus drivers / RAM controller.
interface reu_dma_seq_if;
  logic       BA;
  logic [7:0] C64RDD;
  logic [7:0] REURDD;
  logic       nDMA;
  logic       C64RW;
  logic [7:0] C64WRD;
  logic       REUWE;
  logic [7:0] REUWRD;

  modport master (
    input  BA, C64RDD, REURDD,
    output nDMA, C64RW, C64WRD, REUWE, REUWRD
  );

  modport slave (
    output BA, C64RDD, REURDD,
    input  nDMA, C64RW, C64WRD, REUWE, REUWRD
  );
endinterface

// File: rtl/reu_dma_seq.sv
// REU DMA transfer sequencer: takes the C64 bus and moves/compares one
// byte per BA slot. All outputs are registered on the falling PHI2 edge.
module reu_dma_seq
  import reu_pkg::*;
(
  input  logic          PHI2,
  input  logic          nReset,
  input  logic          ExecuteEN,
  input  logic          FF00DecodeEN,
  input  logic [1:0]    XferType,
  input  logic          Length1,
  input  logic          CPUWrFF00,
  reu_dma_seq_if.master bus,
  output logic          NextCA,
  output logic          NextREUA,
  output logic          VerifyErr,
  output logic          Busy
);

  seqState_t  state, stateD;
  logic [1:0] typeQ, typeD;
  logic [7:0] holdC, holdCD;
  logic [7:0] holdR, holdRD;
  logic       nDMAQ, nDMAD;
  logic       c64RWQ, c64RWD;
  logic [7:0] c64WRDQ, c64WRDD;
  logic       reuWEQ, reuWED;
  logic [7:0] reuWRDQ, reuWRDD;
  logic       nextCAQ, nextREUAQ, verifyErrQ;
  logic       nextCAD, nextREUAD, verifyErrD;
  logic       busyQ, busyD;
  logic       step;
  logic       match;

  always_ff @(negedge PHI2 or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      typeQ      <= STASH;
      holdC      <= 8'h00;
      holdR      <= 8'h00;
      nDMAQ      <= 1'b1;
      c64RWQ     <= 1'b1;
      c64WRDQ    <= 8'h00;
      reuWEQ     <= 1'b0;
      reuWRDQ    <= 8'h00;
      nextCAQ    <= 1'b0;
      nextREUAQ  <= 1'b0;
      verifyErrQ <= 1'b0;
      busyQ      <= 1'b0;
    end else begin
      state      <= stateD;
      typeQ      <= typeD;
      holdC      <= holdCD;
      holdR      <= holdRD;
      nDMAQ      <= nDMAD;
      c64RWQ     <= c64RWD;
      c64WRDQ    <= c64WRDD;
      reuWEQ     <= reuWED;
      reuWRDQ    <= reuWRDD;
      nextCAQ    <= nextCAD;
      nextREUAQ  <= nextREUAD;
      verifyErrQ <= verifyErrD;
      busyQ      <= busyD;
    end
  end

  always_comb begin
    stateD     = state;
    typeD      = typeQ;
    holdCD     = holdC;
    holdRD     = holdR;
    c64RWD     = 1'b1;
    c64WRDD    = c64WRDQ;
    reuWED     = 1'b0;
    reuWRDD    = reuWRDQ;
    nextCAD    = 1'b0;
    nextREUAD  = 1'b0;
    verifyErrD = 1'b0;
    step       = 1'b0;
    match      = (bus.C64RDD == bus.REURDD);

    unique case (state)
      IDLE: begin
        if (ExecuteEN)
          stateD = FF00DecodeEN ? ARM : START;
      end
      ARM: begin
        if (!ExecuteEN)
          stateD = IDLE;
        else if (CPUWrFF00)
          stateD = START;
      end
      START: begin
        if (bus.BA) begin
          stateD = XFER;
          typeD  = XferType;
        end
      end
      XFER: begin
        if (bus.BA) begin
          unique case (typeQ)
            STASH: begin
              reuWED  = 1'b1;
              reuWRDD = bus.C64RDD;
              step    = 1'b1;
            end
            FETCH: begin
              c64RWD  = 1'b0;
              c64WRDD = bus.REURDD;
              step    = 1'b1;
            end
            VERIFY: begin
              if (match) begin
                step = 1'b1;
              end else begin
                verifyErrD = 1'b1;
                stateD     = DONE;
              end
            end
            SWAP: begin
              holdCD = bus.C64RDD;
              holdRD = bus.REURDD;
              stateD = SWAPW;
            end
          endcase
        end
      end
      SWAPW: begin
        if (bus.BA) begin
          c64RWD  = 1'b0;
          c64WRDD = holdR;
          reuWRDD = holdC;
          reuWED  = 1'b1;
          step    = 1'b1;
          stateD  = XFER;
        end
      end
      DONE: begin
        if (!ExecuteEN)
          stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase

    // a completed byte slot advances both addresses; last byte ends the run
    if (step) begin
      nextCAD   = 1'b1;
      nextREUAD = 1'b1;
      if (Length1)
        stateD = DONE;
    end

    nDMAD = !(stateD inside {START, XFER, SWAPW});
    busyD = (stateD != IDLE);
  end

  assign bus.nDMA   = nDMAQ;
  assign bus.C64RW  = c64RWQ;
  assign bus.C64WRD = c64WRDQ;
  assign bus.REUWE  = reuWEQ;
  assign bus.REUWRD = reuWRDQ;
  assign NextCA     = nextCAQ;
  assign NextREUA   = nextREUAQ;
  assign VerifyErr  = verifyErrQ;
  assign Busy       = busyQ;

endmodule
